// File: rtl/clk_div_multi_pkg.sv
// Shared mode/state encodings and the zero-means-one half-period clamp for clk_div_multi.
package clk_div_multi_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HI   = 2'b01,
    ST_LO   = 2'b10
  } step_state_e;

  // Widest divisor the clamp handles; channels size the result back to CNT_W.
  localparam int unsigned HALF_MAX_W = 32;

  function automatic logic [HALF_MAX_W-1:0] clamp_half(input logic [HALF_MAX_W-1:0] v);
    return (v == '0) ? HALF_MAX_W'(1) : v;
  endfunction

  // The reserved encoding 2'b11 behaves as OFF.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_RUN;
      2'b10:   return MODE_STEP;
      default: return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: free-running or single-step divided clock with a shadowed divisor.
// Optional CLK_DIV_MULTI_DUTY_EN adds an independent low-phase length (cfg_low).
//
// state   | meaning
// ST_IDLE | STEP mode waiting for step_req (also parked here in OFF/RUN)
// ST_HI   | STEP high phase, slow_clk=1 for h cycles
// ST_LO   | STEP low phase, slow_clk=0 for the low time, then back to idle
module clk_div_chan #(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned DEF_HALF = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [1:0]       cfg_mode,
`ifdef CLK_DIV_MULTI_DUTY_EN
  input  logic [CNT_W-1:0] cfg_low,
`endif
  input  logic             step_req,
  output logic             slow_clk,
  output logic             tick,
  output logic             step_busy
);
  import clk_div_multi_pkg::*;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(clamp_half(HALF_MAX_W'(DEF_HALF)));

  mode_e            mode_q, mode_d, wr_mode;
  step_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slow_q, slow_d;
  logic             tick_q, tick_d;
  logic             load_act;
  logic [CNT_W-1:0] act_hi_q, shd_hi_q, shd_hi_nxt, lim_lo, lim;

  assign wr_mode    = decode_mode(cfg_mode);
  // A write lands in the shadow this cycle, so a coincident period end already sees it.
  assign shd_hi_nxt = cfg_we ? CNT_W'(clamp_half(HALF_MAX_W'(cfg_half))) : shd_hi_q;

`ifdef CLK_DIV_MULTI_DUTY_EN
  logic [CNT_W-1:0] act_lo_q, shd_lo_q, shd_lo_nxt;
  assign shd_lo_nxt = cfg_we ? CNT_W'(clamp_half(HALF_MAX_W'(cfg_low))) : shd_lo_q;
  assign lim_lo     = act_lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_lo_q <= RST_HALF;
      shd_lo_q <= RST_HALF;
    end else begin
      shd_lo_q <= shd_lo_nxt;
      if (load_act) act_lo_q <= shd_lo_nxt;
    end
  end
`else
  assign lim_lo = act_hi_q;
`endif

  assign lim = slow_q ? act_hi_q : lim_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      slow_q   <= 1'b0;
      tick_q   <= 1'b0;
      act_hi_q <= RST_HALF;
      shd_hi_q <= RST_HALF;
    end else begin
      mode_q   <= mode_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slow_q   <= slow_d;
      tick_q   <= tick_d;
      shd_hi_q <= shd_hi_nxt;
      if (load_act) act_hi_q <= shd_hi_nxt;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    slow_d   = slow_q;
    tick_d   = 1'b0;
    load_act = 1'b0;
    if (cfg_we && (wr_mode != mode_q)) begin
      mode_d   = wr_mode;
      state_d  = ST_IDLE;
      cnt_d    = '0;
      slow_d   = 1'b0;
      load_act = 1'b1;
    end else begin
      case (mode_q)
        MODE_RUN: begin
          if (cnt_q == lim - ONE) begin
            cnt_d    = '0;
            slow_d   = ~slow_q;
            tick_d   = ~slow_q;
            load_act = slow_q;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        MODE_STEP: begin
          case (state_q)
            ST_IDLE: begin
              load_act = 1'b1;
              // A config write in the same cycle takes priority over the step request.
              if (step_req && !cfg_we) begin
                state_d = ST_HI;
                slow_d  = 1'b1;
                tick_d  = 1'b1;
              end
            end
            ST_HI: begin
              if (cnt_q == act_hi_q - ONE) begin
                cnt_d   = '0;
                state_d = ST_LO;
                slow_d  = 1'b0;
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end
            ST_LO: begin
              if (cnt_q == lim_lo - ONE) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
        default: begin
          cnt_d   = '0;
          slow_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    slow_clk  = slow_q;
    tick      = tick_q;
    step_busy = (state_q != ST_IDLE);
  end

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent clock-divider channels sharing one config port.
// Optional CLK_DIV_MULTI_DUTY_EN adds the cfg_low port for a separate low-phase length.
module clk_div_multi #(
  parameter  int unsigned N_CH     = 2,
  parameter  int unsigned CNT_W    = 24,
  parameter  int unsigned DEF_HALF = 5,
  localparam int unsigned SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [1:0]       cfg_mode,
`ifdef CLK_DIV_MULTI_DUTY_EN
  input  logic [CNT_W-1:0] cfg_low,
`endif
  input  logic [N_CH-1:0]  step_req,
  output logic [N_CH-1:0]  slow_clk,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  step_busy
);

  logic [N_CH-1:0] we_ch;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Selects past the last channel match nothing and are dropped.
    assign we_ch[i] = cfg_we && (32'(cfg_sel) == 32'(i));

    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (we_ch[i]),
      .cfg_half  (cfg_half),
      .cfg_mode  (cfg_mode),
`ifdef CLK_DIV_MULTI_DUTY_EN
      .cfg_low   (cfg_low),
`endif
      .step_req  (step_req[i]),
      .slow_clk  (slow_clk[i]),
      .tick      (tick[i]),
      .step_busy (step_busy[i])
    );
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the team's fixed single-output clock divider.
- Each channel produces a divided, square `slow_clk` and a one-cycle `tick` enable in the `clk` domain.
- Each channel has a runtime-programmable half-period and a per-channel run/off/single-step mode.
- Used on board tests to pace the single-cycle MIPS core (free-run or one instruction per button press) and to drive display refresh.

Parameters:
- N_CH, 2, number of independent divider channels (1..8).
- CNT_W, 24, width of the half-period counter and divisor.
- DEF_HALF, 5, half-period loaded into every channel at reset; must be <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe for divisor/mode of channel cfg_sel.
- cfg_sel  in  $clog2(N_CH) (min 1)  target channel index.
- cfg_half  in  CNT_W  new half-period in clk cycles.
- cfg_mode  in  2  00=OFF, 01=RUN, 10=STEP, 11=reserved (treated as OFF).
- step_req  in  N_CH  per-channel single-cycle step request (already debounced, pulse).
- slow_clk  out  N_CH  divided clock level per channel.
- tick  out  N_CH  one-cycle pulse coincident with each slow_clk rising transition.
- step_busy  out  N_CH  high while a STEP-mode period is in progress.

Behaviour:
- Reset (rst=1 at posedge), for every channel:
  - counter=0, slow_clk=0, tick=0, step_busy=0.
  - active half=DEF_HALF, shadow half=DEF_HALF, mode=OFF.
- Divisor: effective half h = max(cfg_half, 1); half=0 is written as 1.
- RUN:
  - counter increments each clk.
  - When counter == h-1: counter wraps to 0 and slow_clk toggles.
  - Output period is 2h clk cycles at 50% duty.
  - tick=1 in the cycle after slow_clk is registered 0->1, i.e. aligned with the registered high level's first cycle.
- Divisor update is glitch-free:
  - cfg_we writes the shadow half immediately.
  - Active half takes the shadow value only at a wrap where slow_clk goes 1->0 (end of full period).
  - A write during a period never shortens or extends the current period.
- Mode writes take effect the next cycle:
  - RUN->OFF: counter=0, slow_clk=0 immediately; no tick.
  - OFF->RUN: starts at counter=0, slow_clk=0; first rising edge after h cycles.
  - Any mode change loads the shadow into the active half.
- STEP channel FSM: IDLE -> HI -> LO -> IDLE.
  - IDLE: slow_clk=0, step_busy=0. On step_req go to HI: slow_clk=1, tick=1, step_busy=1.
  - HI: after h cycles go to LO with slow_clk=0.
  - LO: after h cycles return to IDLE with step_busy=0.
  - step_req while busy is ignored; requests are not queued.
- Same-cycle cfg_we and step_req on the same channel: cfg_we wins (mode/divisor updated), step_req is dropped.
- cfg_we to a cfg_sel >= N_CH is ignored.
- Channels are fully independent; no cross-channel phase relation is guaranteed.
- rst mid-period returns every channel to its reset state on the next cycle.
- The counter never exceeds h-1; no overflow at h = 2^CNT_W-1.

Optional Feature:
- Macro CLK_DIV_MULTI_DUTY_EN.
- Defined:
  - Adds input cfg_low (CNT_W) captured by cfg_we into a shadow low-time.
  - High phase lasts h cycles, low phase lasts max(cfg_low, 1) cycles.
  - This applies in RUN and in STEP's LO phase.
  - Reset low-time is DEF_HALF.
- Undefined: no cfg_low port; low time equals h (50% duty).

Decomposition:
- Package clk_div_multi_pkg holds:
  - mode encodings (MODE_OFF, MODE_RUN, MODE_STEP)
  - step FSM state typedef (ST_IDLE, ST_HI, ST_LO)
  - the "zero means one" half-period clamp function.
- One sub-module, clk_div_chan: a single channel (counter, shadow/active divisor, FSM).
- Top instantiates N_CH copies via generate and decodes cfg_sel into per-channel write strobes.

Test Plan:
- Reset then RUN on ch0, half=3 -> slow_clk period 6 cycles, high 3 / low 3, one tick per period, first rising edge 3 cycles after mode write.
- RUN at half=4, write half=2 mid high phase -> current period stays 8 cycles, next periods 4 cycles, no runt pulse.
- STEP ch1, half=5, step_req pulse -> slow_clk high 5, low 5, step_busy high 10 cycles, one tick; second step_req during busy -> no extra pulse.
- Write half=0 -> slow_clk toggles every cycle (period 2); write to cfg_sel=N_CH -> no channel changes.
- rst asserted mid-period and mid-STEP -> all outputs 0, mode OFF, active half back to DEF_HALF next cycle.
- With CLK_DIV_MULTI_DUTY_EN, half=2, low=6 -> high 2 / low 6, period 8; without the macro the same config gives 2/2.
